// File: rtl/otp_pkg.sv
// Shared state type, register addresses and CTRL bit positions for the OTP
// shadow register file.
package otp_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_LOAD = 2'd1,
      ST_IDLE = 2'd2,
      ST_PROG = 2'd3
   } otp_state_e;

   localparam logic [6:0] OTP_CTRL_ADDR = 7'h7E;
   localparam logic [6:0] OTP_STAT_ADDR = 7'h7F;

   localparam int CTRL_PROG_BIT   = 0;
   localparam int CTRL_RELOAD_BIT = 1;
   localparam int CTRL_LOCK_BIT   = 2;

   function automatic logic [7:0] otp_stat_byte(
      input logic lock,
      input logic busy,
      input logic crc_ok,
      input logic load_done
   );
      return {2'b00, lock, 2'b00, busy, crc_ok, load_done};
   endfunction

endpackage

// File: rtl/otp_cksum.sv
// Modulo-256 byte accumulator used to check the fuse image against its
// stored checksum byte.
module otp_cksum (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= 8'h00;
      end else if (clr) begin
         sum <= 8'h00;
      end else if (add) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/otp_regfile.sv
// Shadow register file and command front-end for the eFuse OTP controller.
// Optional feature: define OTP_REGFILE_LOCK_EN to enable the CTRL LOCK bit.
module otp_regfile
   import otp_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [6:0] i_xbus_addr,
   input  logic [7:0] i_xbus_din,
   input  logic       i_xbus_we,
   output logic [7:0] o_xbus_dout,
   input  logic       i_otp_done,
   output logic       o_otp_read_n,
   output logic       o_otp_prog,
   input  logic [6:0] i_i2c_addr,
   input  logic [7:0] i_i2c_wdata,
   input  logic       i_i2c_wr,
   input  logic       i_i2c_rd,
   output logic [7:0] o_i2c_rdata,
   output logic       o_load_done,
   output logic       o_crc_ok
);

   localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

   otp_state_e         state_reg;
   logic               boot_armed_reg;
   logic               lock_reg;
   logic [8*DEPTH-1:0] shadow_flat;
   logic [7:0]         cksum_sum;
   logic               cksum_clr;
   logic               cksum_add;
   logic               ctrl_wr;
   logic               prog_req;
   logic               reload_req;
   logic               xbus_wr_shadow;
   logic               i2c_wr_shadow;
   logic [7:0]         xbus_rd_byte;
   logic [7:0]         i2c_rd_byte;

   assign ctrl_wr = i_i2c_wr && (i_i2c_addr == OTP_CTRL_ADDR) && (state_reg == ST_IDLE);

`ifdef OTP_REGFILE_LOCK_EN
   // A LOCK written together with PROG already blocks that PROG.
   assign prog_req = ctrl_wr && i_i2c_wdata[CTRL_PROG_BIT]
                     && !lock_reg && !i_i2c_wdata[CTRL_LOCK_BIT];

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_reg <= 1'b0;
      end else if (ctrl_wr && i_i2c_wdata[CTRL_LOCK_BIT]) begin
         lock_reg <= 1'b1;
      end
   end
`else
   assign prog_req = ctrl_wr && i_i2c_wdata[CTRL_PROG_BIT];
   assign lock_reg = 1'b0;
`endif

   assign reload_req = ctrl_wr && i_i2c_wdata[CTRL_RELOAD_BIT] && !prog_req;

   // Fuse bytes only land during LOAD, host bytes only during IDLE, so the
   // two write ports never contend for the same cycle.
   assign xbus_wr_shadow = i_xbus_we && (state_reg == ST_LOAD) && (i_xbus_addr <= LAST_ADDR);
   assign i2c_wr_shadow  = i_i2c_wr && (state_reg == ST_IDLE) && (i_i2c_addr <= LAST_ADDR);

   assign cksum_clr = (state_reg == ST_BOOT) || reload_req;
   assign cksum_add = xbus_wr_shadow && (i_xbus_addr != LAST_ADDR);

   otp_cksum u_cksum (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .clr     (cksum_clr),
      .add     (cksum_add),
      .din     (i_xbus_din),
      .sum     (cksum_sum)
   );

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byte
         localparam logic [6:0] BYTE_ADDR = 7'(gi);
         logic [7:0] byte_reg;

         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
               byte_reg <= 8'h00;
            end else if (xbus_wr_shadow && (i_xbus_addr == BYTE_ADDR)) begin
               byte_reg <= i_xbus_din;
            end else if (i2c_wr_shadow && (i_i2c_addr == BYTE_ADDR)) begin
               byte_reg <= i_i2c_wdata;
            end
         end

         assign shadow_flat[gi*8 +: 8] = byte_reg;
      end
   endgenerate

   always_comb begin
      xbus_rd_byte = 8'h00;
      i2c_rd_byte  = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_xbus_addr == 7'(i)) begin
            xbus_rd_byte = shadow_flat[i*8 +: 8];
         end
         if (i_i2c_addr == 7'(i)) begin
            i2c_rd_byte = shadow_flat[i*8 +: 8];
         end
      end
      if (i_i2c_addr == OTP_STAT_ADDR) begin
         i2c_rd_byte = otp_stat_byte(lock_reg, state_reg != ST_IDLE, o_crc_ok, o_load_done);
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         o_xbus_dout <= 8'h00;
         o_i2c_rdata <= 8'h00;
      end else begin
         o_xbus_dout <= xbus_rd_byte;
         if (i_i2c_rd) begin
            o_i2c_rdata <= i2c_rd_byte;
         end
      end
   end

   // BOOT holds for one full cycle after reset release so the controller
   // sees the load request rise cleanly on the second edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_BOOT;
         boot_armed_reg <= 1'b0;
         o_otp_read_n   <= 1'b1;
         o_otp_prog     <= 1'b0;
         o_load_done    <= 1'b0;
         o_crc_ok       <= 1'b0;
      end else begin
         case (state_reg)
            ST_BOOT: begin
               if (!boot_armed_reg) begin
                  boot_armed_reg <= 1'b1;
               end else begin
                  state_reg    <= ST_LOAD;
                  o_otp_read_n <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (i_otp_done) begin
                  state_reg    <= ST_IDLE;
                  o_otp_read_n <= 1'b1;
                  o_load_done  <= 1'b1;
                  o_crc_ok     <= (cksum_sum == shadow_flat[(DEPTH-1)*8 +: 8]);
               end
            end
            ST_IDLE: begin
               if (prog_req) begin
                  state_reg  <= ST_PROG;
                  o_otp_prog <= 1'b1;
               end else if (reload_req) begin
                  state_reg    <= ST_LOAD;
                  o_otp_read_n <= 1'b0;
                  o_crc_ok     <= 1'b0;
               end
            end
            ST_PROG: begin
               if (i_otp_done) begin
                  state_reg  <= ST_IDLE;
                  o_otp_prog <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_otp_regfile.sv
// Self-checking bench for otp_regfile: directed boot/program/reload/reset
// scenarios followed by randomized traffic against a behavioural model.
module tb_otp_regfile;

   localparam int DEPTH = 4;
   localparam int LAST  = DEPTH - 1;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b1;
   logic [6:0] i_xbus_addr = '0;
   logic [7:0] i_xbus_din  = '0;
   logic       i_xbus_we   = 1'b0;
   logic [7:0] o_xbus_dout;
   logic       i_otp_done  = 1'b0;
   logic       o_otp_read_n;
   logic       o_otp_prog;
   logic [6:0] i_i2c_addr  = '0;
   logic [7:0] i_i2c_wdata = '0;
   logic       i_i2c_wr    = 1'b0;
   logic       i_i2c_rd    = 1'b0;
   logic [7:0] o_i2c_rdata;
   logic       o_load_done;
   logic       o_crc_ok;

   int total = 0;
   int bad   = 0;

   otp_regfile #(.DEPTH(DEPTH)) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .i_xbus_addr  (i_xbus_addr),
      .i_xbus_din   (i_xbus_din),
      .i_xbus_we    (i_xbus_we),
      .o_xbus_dout  (o_xbus_dout),
      .i_otp_done   (i_otp_done),
      .o_otp_read_n (o_otp_read_n),
      .o_otp_prog   (o_otp_prog),
      .i_i2c_addr   (i_i2c_addr),
      .i_i2c_wdata  (i_i2c_wdata),
      .i_i2c_wr     (i_i2c_wr),
      .i_i2c_rd     (i_i2c_rd),
      .o_i2c_rdata  (o_i2c_rdata),
      .o_load_done  (o_load_done),
      .o_crc_ok     (o_crc_ok)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural model: byte image, boot edge count, activity flags, running load sum.
   logic [8*DEPTH-1:0] m_mem;
   int                 m_boot;
   int                 m_sum;
   logic               m_loading, m_prog, m_done_any, m_crc, m_lock;
   logic [7:0]         m_xdout, m_rdata;

   function automatic logic m_idle();
      return (m_boot >= 2) && !m_loading && !m_prog;
   endfunction

   function automatic logic [7:0] m_byte(input logic [6:0] a);
      if (int'(a) < DEPTH) return m_mem[int'(a)*8 +: 8];
      return 8'h00;
   endfunction

   function automatic logic [7:0] m_stat();
      return {2'b00, m_lock, 2'b00, !m_idle(), m_crc, m_done_any};
   endfunction

   task automatic model_reset();
      m_mem = '0; m_boot = 0; m_sum = 0;
      m_loading = 1'b0; m_prog = 1'b0; m_done_any = 1'b0; m_crc = 1'b0; m_lock = 1'b0;
      m_xdout = 8'h00; m_rdata = 8'h00;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_xdout = m_byte(i_xbus_addr);
      if (i_i2c_rd) m_rdata = (i_i2c_addr == 7'h7F) ? m_stat() : m_byte(i_i2c_addr);
      if (m_boot < 2) begin
         m_boot++;
         if (m_boot == 2) begin
            m_loading = 1'b1;
            m_sum = 0;
         end
      end else if (m_loading) begin
         if (i_otp_done) begin
            m_loading = 1'b0;
            m_done_any = 1'b1;
            m_crc = ((m_sum % 256) == int'(m_mem[LAST*8 +: 8]));
         end
         if (i_xbus_we && int'(i_xbus_addr) < DEPTH) begin
            m_mem[int'(i_xbus_addr)*8 +: 8] = i_xbus_din;
            if (int'(i_xbus_addr) < LAST) m_sum = m_sum + int'(i_xbus_din);
         end
      end else if (m_prog) begin
         if (i_otp_done) m_prog = 1'b0;
      end else begin
         if (i_i2c_wr && int'(i_i2c_addr) < DEPTH) m_mem[int'(i_i2c_addr)*8 +: 8] = i_i2c_wdata;
         if (i_i2c_wr && i_i2c_addr == 7'h7E) begin
`ifdef OTP_REGFILE_LOCK_EN
            if (i_i2c_wdata[2]) m_lock = 1'b1;
`endif
            if (i_i2c_wdata[0] && !m_lock) begin
               m_prog = 1'b1;
            end else if (i_i2c_wdata[1]) begin
               m_loading = 1'b1;
               m_sum = 0;
               m_crc = 1'b0;
            end
         end
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk1("read_n", o_otp_read_n, !m_loading);
      chk1("prog", o_otp_prog, m_prog);
      chk1("load_done", o_load_done, m_done_any);
      chk1("crc_ok", o_crc_ok, m_crc);
      chk8("xbus_dout", o_xbus_dout, m_xdout);
      chk8("i2c_rdata", o_i2c_rdata, m_rdata);
   endtask

   // One clock: inputs were set after the previous falling edge.
   task automatic cycle();
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      compare_all();
   endtask

   task automatic clr_strobes();
      i_xbus_we = 1'b0; i_i2c_wr = 1'b0; i_i2c_rd = 1'b0; i_otp_done = 1'b0;
   endtask

   task automatic xwr(input logic [6:0] a, input logic [7:0] d);
      i_xbus_addr = a; i_xbus_din = d; i_xbus_we = 1'b1;
      cycle();
      clr_strobes();
   endtask

   task automatic iwr(input logic [6:0] a, input logic [7:0] d);
      i_i2c_addr = a; i_i2c_wdata = d; i_i2c_wr = 1'b1;
      cycle();
      clr_strobes();
   endtask

   task automatic ird(input logic [6:0] a);
      i_i2c_addr = a; i_i2c_rd = 1'b1;
      cycle();
      clr_strobes();
   endtask

   task automatic pulse_done();
      i_otp_done = 1'b1;
      cycle();
      clr_strobes();
   endtask

   task automatic release_and_boot();
      rst_n = 1'b1;
      cycle();
      chk1("boot_edge1_read_n", o_otp_read_n, 1'b1);
      cycle();
      chk1("boot_edge2_read_n", o_otp_read_n, 1'b0);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      cycle();
      cycle();
      chk1("rst_read_n", o_otp_read_n, 1'b1);
      chk1("rst_prog", o_otp_prog, 1'b0);
      chk1("rst_load_done", o_load_done, 1'b0);
      chk8("rst_xbus_dout", o_xbus_dout, 8'h00);
      chk8("rst_i2c_rdata", o_i2c_rdata, 8'h00);
      release_and_boot();

      // Good boot load: 0x11+0x22+0x33 = 0x66.
      xwr(7'd0, 8'h11); xwr(7'd1, 8'h22); xwr(7'd2, 8'h33); xwr(7'd3, 8'h66);
      pulse_done();
      chk1("load_read_n", o_otp_read_n, 1'b1);
      chk1("load_done", o_load_done, 1'b1);
      chk1("load_crc_ok", o_crc_ok, 1'b1);
      ird(7'h7F);
      chk8("stat_good", o_i2c_rdata, 8'h03);

      // Reload with a wrong checksum byte.
      iwr(7'h7E, 8'h02);
      chk1("reload_read_n", o_otp_read_n, 1'b0);
      chk1("reload_crc_clr", o_crc_ok, 1'b0);
      xwr(7'd0, 8'h11); xwr(7'd1, 8'h22); xwr(7'd2, 8'h33); xwr(7'd3, 8'h65);
      pulse_done();
      chk1("bad_crc_ok", o_crc_ok, 1'b0);
      ird(7'h7F);
      chk8("stat_bad", o_i2c_rdata, 8'h01);

      // Program cycle.
      iwr(7'd1, 8'h66);
      iwr(7'h7E, 8'h01);
      chk1("prog_on", o_otp_prog, 1'b1);
      chk1("prog_read_n", o_otp_read_n, 1'b1);
      i_xbus_addr = 7'd1;
      cycle();
      chk8("prog_xbus_dout", o_xbus_dout, 8'h66);
      iwr(7'd1, 8'h00);
      ird(7'd1);
      chk8("prog_wr_ignored", o_i2c_rdata, 8'h66);
      ird(7'h7F);
      chk8("stat_prog", o_i2c_rdata, 8'h05);
      pulse_done();
      chk1("prog_off", o_otp_prog, 1'b0);

      // Reload with a same-cycle collision on byte 0.
      iwr(7'h7E, 8'h02);
      chk1("reload2_read_n", o_otp_read_n, 1'b0);
      i_i2c_addr = 7'd0; i_i2c_wdata = 8'hAA; i_i2c_wr = 1'b1;
      i_xbus_addr = 7'd0; i_xbus_din = 8'h55; i_xbus_we = 1'b1;
      cycle();
      clr_strobes();
      ird(7'd0);
      chk8("collision_byte", o_i2c_rdata, 8'h55);
      xwr(7'd1, 8'h22); xwr(7'd2, 8'h33); xwr(7'd3, 8'hAA);
      pulse_done();
      chk1("collision_crc_ok", o_crc_ok, 1'b1);

      // Asynchronous reset while programming.
      iwr(7'h7E, 8'h01);
      chk1("prog_on2", o_otp_prog, 1'b1);
      i_xbus_addr = 7'd1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk1("async_prog", o_otp_prog, 1'b0);
      chk1("async_read_n", o_otp_read_n, 1'b1);
      chk8("async_xbus_dout", o_xbus_dout, 8'h00);
      chk1("async_load_done", o_load_done, 1'b0);
      cycle();
      release_and_boot();
      ird(7'd1);
      chk8("byte_after_reset", o_i2c_rdata, 8'h00);
      xwr(7'd3, 8'h00);
      pulse_done();
      chk1("empty_load_crc", o_crc_ok, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         int sel;
         i_xbus_addr = 7'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) i_xbus_addr = 7'h7E;
         i_xbus_din  = 8'($urandom);
         i_otp_done  = ($urandom_range(0, 11) == 0);
         i_xbus_we   = !i_otp_done && ($urandom_range(0, 2) == 0);
         i_i2c_rd    = ($urandom_range(0, 2) == 0);
         sel = int'($urandom_range(0, 9));
         if (sel < 6) i_i2c_addr = 7'(sel);
         else if (sel < 8) i_i2c_addr = 7'h7F;
         else i_i2c_addr = 7'h7E;
         if (i_i2c_addr == 7'h7E) begin
            i_i2c_wdata = 8'($urandom_range(0, 3));
            i_i2c_wr    = !m_loading && ($urandom_range(0, 3) == 0);
         end else begin
            i_i2c_wdata = 8'($urandom);
            i_i2c_wr    = !m_loading && ($urandom_range(0, 3) == 0);
         end
         cycle();
      end
      clr_strobes();
      cycle();

`ifdef OTP_REGFILE_LOCK_EN
      #2 rst_n = 1'b0;
      model_reset();
      cycle();
      release_and_boot();
      pulse_done();
      iwr(7'h7E, 8'h04);
      iwr(7'h7E, 8'h01);
      chk1("lock_prog_blocked", o_otp_prog, 1'b0);
      ird(7'h7F);
      chk1("lock_stat_bit5", o_i2c_rdata[5], 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
